// File: rtl/pe_ifmap_buffer.sv
// pe_ifmap_buffer: circular input-feature-map buffer feeding a PE.
// Entries are pushed at the write pointer. A window of FILT_SIZE elements,
// starting at the base pointer, is streamed out on a valid/ready port.
// When a window retires, the base pointer advances by STRIDE entries.
// Optional feature: define IFBUF_ZPAD_EN to add the zpad input. With zpad
// set, a window emits FILT_SIZE zeros and leaves the base pointer and count
// unchanged.
module pe_ifmap_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int FILT_SIZE  = 4,
  parameter int STRIDE     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  start,
`ifdef IFBUF_ZPAD_EN
  input  logic                  zpad,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  out_last,
  output logic                  done
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]         FILT_CNT  = CW'(FILT_SIZE);
  localparam logic [CW-1:0]         STR_CNT   = CW'(STRIDE);
  localparam logic [ADDR_WIDTH-1:0] STR_PTR   = ADDR_WIDTH'(STRIDE);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(FILT_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_PTR   = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_DRAIN} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wp_q, wp_d;
  logic [ADDR_WIDTH-1:0] bp_q, bp_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  done_q, done_d;
  logic                  zpad_q, zpad_d;
  logic                  zpad_req;
  logic                  push;
  logic                  retire;
  logic                  load_en;
  logic [ADDR_WIDTH-1:0] rd_addr;

`ifdef IFBUF_ZPAD_EN
  assign zpad_req = zpad;

  // Remember whether the current window is a zero-padding window.
  always_ff @(posedge clk) begin
    if (rst) zpad_q <= 1'b0;
    else     zpad_q <= zpad_d;
  end
`else
  assign zpad_req = 1'b0;
  assign zpad_q   = 1'b0;
`endif

  // Count bounds pushes so a write never lands on an unread window entry.
  assign in_ready = (count_q < DEPTH_CNT) && !rst;
  assign push     = in_valid && in_ready;
  assign rd_addr  = bp_q + idx_q;  // wraps naturally: DEPTH is a power of two
  assign wp_d     = push ? wp_q + ONE_PTR : wp_q;
  assign count_d  = count_q + CW'(push) - (retire ? STR_CNT : '0);

  // Window sequencing: next state, read index and output handshake flags.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    bp_d        = bp_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    zpad_d      = zpad_q;
    load_en     = 1'b0;
    retire      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d  = '0;
          zpad_d = zpad_req;
          if (zpad_req || count_q >= FILT_CNT) state_d = S_READ;
          else                                 state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (count_q >= FILT_CNT) begin
          idx_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (!out_valid_q || out_ready) begin
          load_en     = 1'b1;
          out_valid_d = 1'b1;
          out_last_d  = (idx_q == LAST_IDX);
          idx_d       = idx_q + ONE_PTR;
          if (idx_q == LAST_IDX) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          state_d     = S_IDLE;
          if (!zpad_q) begin
            retire = 1'b1;
            bp_d   = bp_q + STR_PTR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wp_q        <= '0;
      bp_q        <= '0;
      idx_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      bp_q        <= bp_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  // Storage array write port. It has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= din;
  end

  // Registered read port that feeds dout.
  always_ff @(posedge clk) begin
    if (rst)          dout_q <= '0;
    else if (load_en) dout_q <= zpad_q ? '0 : mem[rd_addr];
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign dout      = dout_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pe_ifmap_buffer.sv
// Testbench for pe_ifmap_buffer with DATA_WIDTH=8, DEPTH=8, FILT_SIZE=3 and
// STRIDE=1. It applies a table of directed vectors, then hand-written
// sequences for the full buffer, pointer wrap, reset abort and WAIT.
module tb_pe_ifmap_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] din;
  logic       start;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] dout;
  logic       out_last;
  logic       done;

  int n_checks = 0;
  int n_pass   = 0;

  pe_ifmap_buffer #(
    .DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3), .FILT_SIZE(3), .STRIDE(1)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .start(start), .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       iv;
    logic [7:0] d;
    logic       st;
    logic       ordy;
    logic       e_ov;
    logic [7:0] e_dout;
    logic       e_last;
    logic       e_done;
    logic       e_ir;
  } vec_t;

  vec_t vec [18];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one full window with out_ready held high and checks every cycle.
  task automatic run_window(input int e0, input int e1, input int e2);
    start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    check("win_start_ov", int'(out_valid), 0);
    step();
    check("win_e0", int'(dout), e0);
    check("win_e0_last", int'(out_last), 0);
    step();
    check("win_e1", int'(dout), e1);
    step();
    check("win_e2", int'(dout), e2);
    check("win_e2_last", int'(out_last), 1);
    step();
    check("win_done", int'(done), 1);
    check("win_done_ov", int'(out_valid), 0);
    step();
    check("win_done_pulse", int'(done), 0);
    $display("window %0d,%0d,%0d checked", e0, e1, e2);
  endtask

  initial begin
    int got;
    // in_valid, din, start, out_ready | out_valid, dout, out_last, done, in_ready
    vec[0]  = '{1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
    vec[1]  = '{1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
    vec[2]  = '{1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
    vec[3]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
    vec[4]  = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0, 1'b1};
    vec[5]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 1'b1};
    vec[6]  = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 8'd3, 1'b1, 1'b0, 1'b1};
    vec[7]  = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1};
    vec[8]  = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
    vec[9]  = '{1'b1, 8'd4, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
    vec[10] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
    vec[11] = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 1'b1};
    vec[12] = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b1};
    vec[13] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b1};
    vec[14] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b1};
    vec[15] = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 8'd4, 1'b1, 1'b0, 1'b1};
    vec[16] = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1};
    vec[17] = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b1; din = 8'hAA; start = 1'b1; out_ready = 1'b0;
    step();
    step();
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_last", int'(out_last), 0);
    check("rst_done", int'(done), 0);
    $display("reset state checked");
    rst = 1'b0; in_valid = 1'b0; start = 1'b0;

    // Basic window, then a window stalled for two cycles on its second element.
    for (int i = 0; i < 18; i++) begin
      in_valid = vec[i].iv; din = vec[i].d; start = vec[i].st; out_ready = vec[i].ordy;
      step();
      check($sformatf("v%0d_out_valid", i), int'(out_valid), int'(vec[i].e_ov));
      if (vec[i].e_ov)
        check($sformatf("v%0d_dout", i), int'(dout), int'(vec[i].e_dout));
      check($sformatf("v%0d_out_last", i), int'(out_last), int'(vec[i].e_last));
      check($sformatf("v%0d_done", i), int'(done), int'(vec[i].e_done));
      check($sformatf("v%0d_in_ready", i), int'(in_ready), int'(vec[i].e_ir));
      $display("vector %0d: ov=%0d dout=%0d last=%0d done=%0d ir=%0d",
               i, out_valid, dout, out_last, done, in_ready);
    end
    in_valid = 1'b0; start = 1'b0;

    // Two entries remain (3,4). Six more pushes fill the buffer; the ninth offer is refused.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; din = 8'(5 + i);
      step();
      check($sformatf("fill%0d_in_ready", i), int'(in_ready), (i < 5) ? 1 : 0);
      $display("push %0d in_ready=%0d", 5 + i, in_ready);
    end
    din = 8'd99;
    step();
    check("full_in_ready", int'(in_ready), 0);
    in_valid = 1'b0;
    $display("ninth push offered while full");

    // Windows walk the base pointer from 2 through 6; the last one reads entries 6,7,0.
    run_window(3, 4, 5);
    check("after_retire_in_ready", int'(in_ready), 1);
    run_window(4, 5, 6);
    run_window(5, 6, 7);
    run_window(6, 7, 8);
    run_window(7, 8, 9);

    // Reset in the middle of a window: no done pulse, and the buffer is emptied.
    start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    check("abort_pre_ov", int'(out_valid), 1);
    check("abort_pre_dout", int'(dout), 8);
    rst = 1'b1;
    step();
    check("abort_ov", int'(out_valid), 0);
    check("abort_done", int'(done), 0);
    check("abort_in_ready", int'(in_ready), 0);
    rst = 1'b0;
    step();
    check("abort_post_done", int'(done), 0);
    check("abort_post_in_ready", int'(in_ready), 1);
    $display("reset mid-window checked");

    // Start with only one entry stored: WAIT until two more arrive, then read.
    in_valid = 1'b1; din = 8'h21;
    step();
    in_valid = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("wait%0d_ov", i), int'(out_valid), 0);
    end
    in_valid = 1'b1; din = 8'h22;
    step();
    din = 8'h23;
    step();
    in_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 5 && got == 0; i++) begin
      step();
      if (out_valid) got = 1;
    end
    check("wait_read_started", got, 1);
    check("wait_e0", int'(dout), 'h21);
    step();
    check("wait_e1", int'(dout), 'h22);
    step();
    check("wait_e2", int'(dout), 'h23);
    check("wait_e2_last", int'(out_last), 1);
    step();
    check("wait_done", int'(done), 1);
    $display("WAIT window checked");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pe_ifmap_buffer.md
PE_IFMAP_BUFFER -- requirements
Module: pe_ifmap_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, element width in bits.
REQ-002 Parameter DEPTH, default 16, buffer entries, power of two.
REQ-003 Parameter ADDR_WIDTH, default 4, log2(DEPTH).
REQ-004 Parameter FILT_SIZE, default 4, elements per window, 1..DEPTH.
REQ-005 Parameter STRIDE, default 1, entries freed per window, 1..FILT_SIZE.
REQ-006 clk  input  1  single clock; all state changes on the rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 in_valid  input  1  write data offered.
REQ-009 in_ready  output  1  buffer can accept; equals (count < DEPTH) and not rst.
REQ-010 din  input  DATA_WIDTH  write data.
REQ-011 start  input  1  request one window read.
REQ-012 out_valid  output  1  dout holds a window element.
REQ-013 out_ready  input  1  consumer accepts dout.
REQ-014 dout  output  DATA_WIDTH  registered window element.
REQ-015 out_last  output  1  dout is element FILT_SIZE-1 of the window.
REQ-016 done  output  1  one-cycle pulse, window retired and pointers advanced.

Function
REQ-017 Storage: circular buffer, write pointer wp, base pointer bp, count of valid entries; pointers wrap modulo DEPTH.
REQ-018 Push: in_valid && in_ready writes din to mem[wp]; wp increments by 1.
REQ-019 in_valid while full: no write, wp and count unchanged.
REQ-020 FSM states IDLE, WAIT, READ, DRAIN.
REQ-021 IDLE: start with count >= FILT_SIZE -> READ, idx=0; start with count < FILT_SIZE -> WAIT; no start -> IDLE.
REQ-022 WAIT: count >= FILT_SIZE -> READ, idx=0.
REQ-023 READ: each cycle with (!out_valid || out_ready): dout=mem[(bp+idx) mod DEPTH], out_valid=1, out_last=(idx==FILT_SIZE-1), idx++; after loading idx FILT_SIZE-1 -> DRAIN.
REQ-024 READ with out_valid && !out_ready: dout, out_last, idx held.
REQ-025 DRAIN: when out_ready, out_valid=0, out_last=0, bp += STRIDE, done=1 for one cycle, -> IDLE.
REQ-026 Latency: start accepted in IDLE with sufficient data at edge k -> first out_valid after edge k+1; with out_ready held high, one element per cycle, done after edge k+FILT_SIZE+1.
REQ-027 count_next = count + push - (STRIDE if DRAIN retires); push and retire in same cycle both apply.
REQ-028 Window reads never alias writes: count limits push to unread entries.
REQ-029 start in WAIT, READ or DRAIN is ignored.
REQ-030 bp+idx and bp+STRIDE wrap modulo DEPTH.

Reset
REQ-031 rst at an edge: wp=0, bp=0, count=0, idx=0, state=IDLE, dout=0, out_valid=0, out_last=0, done=0.
REQ-032 While rst is high in_ready=0, pushes and start are ignored.
REQ-033 rst mid-window aborts it; no done pulse, buffer contents discarded.

Configuration
REQ-034 Macro IFBUF_ZPAD_EN: when defined, adds input zpad (1 bit); start with zpad=1 in IDLE -> READ regardless of count, emits FILT_SIZE zeros, DRAIN pulses done but leaves bp and count unchanged.
REQ-035 Without IFBUF_ZPAD_EN: zpad port absent; all windows read stored data.

Verification (DATA_WIDTH=8, DEPTH=8, FILT_SIZE=3, STRIDE=1)
REQ-036 Push 1,2,3; start; out_ready=1 -> dout 1,2,3 on consecutive cycles, out_last on 3, done next cycle, count=2.
REQ-037 Push 8 values, 9th in_valid -> in_ready=0, 9th not stored, count=8.
REQ-038 start with count=1, push 2 more -> WAIT then READ, window emits three stored values in order.
REQ-039 out_ready low 2 cycles on element 2 -> dout held at element 2, no element lost, done delayed 2 cycles.
REQ-040 Advance bp to 6, windows read entries 6,7,0 -> correct wrap-around data.
REQ-041 rst asserted during READ -> next cycle out_valid=0, count=0, no done pulse.
